// File: rtl/transmitter_pkg.sv
// uartUtil: shared types and constants for the UART transmit path.
//   states_t  - transmitter frame states (IDLE, START, SEND, STOP)
//   START_BIT - line level of the start bit
//   STOP_BIT  - line level of the stop bit (also the idle level)
//   DATA_BITS - payload bits per frame
package uartUtil;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    STOP  = 2'd3
  } states_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/transmitter_baud_tick.sv
// baud_tick: bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   clear   - restart the period at 0 on the next edge (state entry / idle)
//   bitTick - high in the final cycle of the current bit period
module baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bitTick
);

  localparam int W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear || bitTick) count <= '0;
    else                         count <= count + W'(1);
  end

  assign bitTick = (count == LAST);

endmodule

// File: rtl/transmitter.sv
// transmitter: UART 8N1 transmit stage (start bit, 8 data bits LSB first,
// stop bit). Bytes are accepted through a valid/ready handshake.
// Optional feature macro: UART_TX_HOLD_REG_EN adds a one-byte holding
// register so the next byte can be accepted while a frame is on the line,
// giving back-to-back frames.
// Ports:
//   clk               - system clock, rising edge
//   rst               - synchronous active-high reset
//   byteToSend[7:0]   - byte to transmit, sampled on accept
//   sendValid         - byteToSend is valid
//   sendReady         - a byte can be accepted this cycle
//   transmitterOutput - registered serial line, idles high
//   busy              - a frame is in progress
//   done              - high in the final cycle of each stop bit
//
// state | meaning
// IDLE  | line high, waiting for a byte
// START | start bit on the line
// SEND  | data bits on the line, LSB first
// STOP  | stop bit on the line
module transmitter
  import uartUtil::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byteToSend,
  input  logic       sendValid,
  output logic       sendReady,
  output logic       transmitterOutput,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  states_t    state, stateNext;
  logic [7:0] shiftReg, shiftNext, loadByte;
  logic [2:0] bitCounter, bitCntNext;
  logic       bitTick, accept, startReq, pending, lineNext, clearTick;

  assign accept = sendValid && sendReady;

`ifdef UART_TX_HOLD_REG_EN
  logic [7:0] holdReg;
  logic       holdFull, transfer;

  assign sendReady = !holdFull;
  assign startReq  = holdFull;
  assign pending   = holdFull;
  assign loadByte  = holdReg;
  // A frame start (from IDLE or straight out of STOP) consumes the held byte.
  assign transfer  = (stateNext == START) && (state != START);

  always_ff @(posedge clk) begin
    if (rst) begin
      holdReg  <= 8'h00;
      holdFull <= 1'b0;
    end else if (accept) begin
      // A new byte wins over a same-cycle transfer: the flag stays set.
      holdReg  <= byteToSend;
      holdFull <= 1'b1;
    end else if (transfer) begin
      holdFull <= 1'b0;
    end
  end
`else
  assign sendReady = (state == IDLE);
  assign startReq  = accept;
  assign pending   = 1'b0;
  assign loadByte  = byteToSend;
`endif

  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitCntNext = 3'd0;
    case (state)
      IDLE:  if (startReq) stateNext = START;
      START: if (bitTick) stateNext = SEND;
      SEND: begin
        bitCntNext = bitCounter;
        if (bitTick) begin
          shiftNext  = shiftReg >> 1;
          bitCntNext = bitCounter + 3'd1;
          if (bitCounter == LAST_BIT) stateNext = STOP;
        end
      end
      STOP:  if (bitTick) stateNext = pending ? START : IDLE;
      default: stateNext = IDLE;
    endcase

    if ((stateNext == START) && (state != START)) shiftNext = loadByte;

    // The line is registered from the next state so the start bit appears
    // one cycle after accept.
    case (stateNext)
      START:   lineNext = START_BIT;
      SEND:    lineNext = shiftNext[0];
      default: lineNext = STOP_BIT;
    endcase
  end

  assign clearTick = (state == IDLE) || (stateNext != state);

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (clearTick),
    .bitTick (bitTick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      shiftReg          <= 8'h00;
      bitCounter        <= 3'd0;
      transmitterOutput <= 1'b1;
    end else begin
      state             <= stateNext;
      shiftReg          <= shiftNext;
      bitCounter        <= bitCntNext;
      transmitterOutput <= lineNext;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == STOP) && bitTick;

endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: self-checking bench for transmitter.
// dut1 runs with one clock per bit and feeds a deserialising monitor that
// scoreboards received bytes; dut4 runs with four clocks per bit.
module tb_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, sendValid1, sendReady1, tx1, busy1, done1;
  logic [7:0] byte1;
  logic       rst4, sendValid4, sendReady4, tx4, busy4, done4;
  logic [7:0] byte4;

  transmitter #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst1), .byteToSend(byte1), .sendValid(sendValid1),
    .sendReady(sendReady1), .transmitterOutput(tx1), .busy(busy1), .done(done1)
  );

  transmitter #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst4), .byteToSend(byte4), .sendValid(sendValid4),
    .sendReady(sendReady4), .transmitterOutput(tx4), .busy(busy4), .done(done4)
  );

`ifdef UART_TX_HOLD_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  int compared   = 0;
  int mismatched = 0;
  int framesSeen = 0;
  int expFrames  = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] b;
    logic [9:0] line;  // line[i] = level in frame cycle i+1
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Deserialising monitor on dut1 (one sample per bit).
  initial begin
    logic       inFrame;
    int         idx;
    logic [7:0] rxData;
    inFrame = 1'b0;
    idx     = 0;
    rxData  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst1) begin
        if (inFrame && sb.size() > 0) void'(sb.pop_front());
        inFrame = 1'b0;
      end else if (!inFrame) begin
        chk("mon_done_idle", done1, 0);
        if (tx1 == 1'b0) begin
          inFrame = 1'b1;
          idx     = 0;
        end
      end else if (idx < 8) begin
        chk("mon_done_data", done1, 0);
        rxData[idx] = tx1;
        idx++;
      end else begin
        chk("mon_stop_bit", tx1, 1);
        chk("mon_done_stop", done1, 1);
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL mon_rx_byte: got %0h expected none (scoreboard empty)", rxData);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (rxData !== e) begin
            mismatched++;
            $display("FAIL mon_rx_byte: got %0h expected %0h", rxData, e);
          end
        end
        framesSeen++;
        inFrame = 1'b0;
      end
    end
  end

  task automatic wait_ready1();
    int n = 0;
    while (!sendReady1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready1_timeout", sendReady1, 1);
  endtask

  // Returns one ns after the accepting edge, i.e. in frame cycle 1.
  task automatic accept1(input logic [7:0] b);
    @(posedge clk); #1;
    wait_ready1();
    byte1      = b;
    sendValid1 = 1'b1;
    sb.push_back(b);
    expFrames++;
    @(posedge clk); #1;
    sendValid1 = 1'b0;
    byte1      = 8'($urandom);
  endtask

  task automatic check_frame1(input vec_t v);
    repeat (LAT - 1) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("line1_%0h[%0d]", v.b, c), tx1, v.line[c]);
      chk($sformatf("busy1[%0d]", c), busy1, 1);
      chk($sformatf("done1[%0d]", c), done1, (c == 9));
`ifndef UART_TX_HOLD_REG_EN
      chk($sformatf("ready1_in_frame[%0d]", c), sendReady1, 0);
`endif
    end
    @(negedge clk);
    chk("line1_after", tx1, 1);
    chk("busy1_after", busy1, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish before 300000");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h5A, 10'b1010110100};
    vecs[4] = '{8'h80, 10'b1100000000};
    vecs[5] = '{8'h96, 10'b1100101100};
    vecs[6] = '{8'h01, 10'b1000000010};

    rst1 = 1'b1; sendValid1 = 1'b0; byte1 = 8'h00;
    rst4 = 1'b1; sendValid4 = 1'b0; byte4 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);
    chk("rst_line1", tx1, 1);
    chk("rst_ready1", sendReady1, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_line4", tx4, 1);
    chk("rst_ready4", sendReady4, 1);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);

    for (int i = 0; i < 6; i++) begin
      accept1(vecs[i].b);
      check_frame1(vecs[i]);
    end

    // Four clocks per bit: every level held for four cycles.
    begin
      int n = 0;
      @(posedge clk); #1;
      while (!sendReady4 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("ready4_timeout", sendReady4, 1);
      byte4      = vecs[6].b;
      sendValid4 = 1'b1;
      @(posedge clk); #1;
      sendValid4 = 1'b0;
      byte4      = 8'h00;
      repeat (LAT - 1) @(negedge clk);
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        chk($sformatf("line4[%0d]", c), tx4, vecs[6].line[c / 4]);
        chk($sformatf("busy4[%0d]", c), busy4, 1);
        chk($sformatf("done4[%0d]", c), done4, (c == 39));
      end
      @(negedge clk);
      chk("line4_after", tx4, 1);
      chk("busy4_after", busy4, 0);
    end

    // Reset in frame cycle 5 truncates the frame; the next byte is clean.
    accept1(8'hC3);
    repeat (LAT - 1) @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst1 = 1'b1;
    expFrames--;
    @(posedge clk); #1;
    rst1 = 1'b0;
    @(negedge clk);
    chk("midrst_line", tx1, 1);
    chk("midrst_busy", busy1, 0);
    chk("midrst_ready", sendReady1, 1);
    chk("midrst_done", done1, 0);
    accept1(vecs[5].b);
    check_frame1(vecs[5]);

`ifndef UART_TX_HOLD_REG_EN
    // A byte offered while not ready is dropped.
    accept1(vecs[0].b);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("drop_line[%0d]", c), tx1, vecs[0].line[c]);
      if (c == 2) begin
        sendValid1 = 1'b1;
        byte1      = 8'h3C;
      end
      if (c == 3) sendValid1 = 1'b0;
    end
    repeat (6) begin
      @(negedge clk);
      chk("drop_idle_line", tx1, 1);
      chk("drop_idle_busy", busy1, 0);
    end
`else
    // Valid held high with three bytes: frames run back to back.
    begin
      logic [7:0] hb[3];
      logic       busyLog[40];
      logic       lineLog[40];
      logic       r;
      int         k;
      hb[0] = 8'h11; hb[1] = 8'h22; hb[2] = 8'h33;
      k = 0;
      @(posedge clk); #1;
      sendValid1 = 1'b1;
      byte1      = hb[0];
      for (int cy = 1; cy < 40; cy++) begin
        r = sendReady1;
        @(negedge clk);
        busyLog[cy] = busy1;
        lineLog[cy] = tx1;
        @(posedge clk); #1;
        if (r && sendValid1) begin
          sb.push_back(hb[k]);
          expFrames++;
          k++;
          if (k == 2) chk("hold_ready_after_2nd", sendReady1, 0);
          if (k < 3) byte1 = hb[k];
          else       sendValid1 = 1'b0;
        end
      end
      chk("hold_accepts", k, 3);
      for (int cy = 1; cy < 37; cy++)
        chk($sformatf("hold_busy[%0d]", cy), busyLog[cy], (cy >= 3 && cy <= 32));
      chk("hold_stop1", lineLog[12], 1);
      chk("hold_start2", lineLog[13], 0);
      chk("hold_stop2", lineLog[22], 1);
      chk("hold_start3", lineLog[23], 0);
    end
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("frames_seen", framesSeen, expFrames);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
